// File: rtl/engine_frame_sequencer_pkg.sv
// Shared definitions for the engine frame sequencer: state encodings and
// default parameter values used by the top and its counters.
package engine_frame_sequencer_pkg;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_N_LANES        = 2;
  localparam int DEF_N_PIPELINES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_CTR_WIDTH      = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GAIN    = 3'd1,
    ST_TICK    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_PROCESS = 3'd4,
    ST_MIX     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/engine_frame_sequencer_sat_counter.sv
// Statistics counter with optional saturation at all-ones; otherwise wraps.
module sat_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             sat_en,
  output logic [width-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !(sat_en && (&count))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/engine_frame_sequencer.sv
// Per-frame sequencer: gain handshake, pipeline tick, completion wait with
// timeout, mixer handshake and registered output frame plus statistics.
module engine_frame_sequencer
  import engine_frame_sequencer_pkg::*;
#(
  parameter int data_width     = DEF_DATA_WIDTH,
  parameter int n_lanes        = DEF_N_LANES,
  parameter int n_pipelines    = DEF_N_PIPELINES,
  parameter int timeout_cycles = DEF_TIMEOUT_CYCLES,
  parameter int ctr_width      = DEF_CTR_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [n_lanes*data_width-1:0] in_frame,
  input  logic                          sample_ready,
  input  logic                          gain_bypass,
  output logic [n_lanes*data_width-1:0] gain_frame,
  output logic                          gain_valid,
  input  logic                          gain_ready,
  output logic                          pipeline_tick,
  input  logic [n_pipelines-1:0]        pipelines_ready,
  input  logic [n_pipelines-1:0]        pipelines_enabled,
  output logic                          mix_valid,
  input  logic                          mix_ready,
  input  logic [n_lanes*data_width-1:0] mixed_frame,
  output logic [n_lanes*data_width-1:0] out_frame,
  output logic                          out_valid,
  output logic                          ready,
  output logic [ctr_width-1:0]          frame_count,
  output logic [ctr_width-1:0]          overrun_count,
  output logic [ctr_width-1:0]          timeout_count,
  output logic [2:0]                    state_dbg
);

  localparam int dwell_w = $clog2(timeout_cycles);
  localparam logic [dwell_w-1:0] dwell_last = dwell_w'(timeout_cycles - 1);

  seq_state_t         state;
  logic [dwell_w-1:0] dwell;
  logic               pipes_done;
  logic               timeout_hit;
  logic               frame_inc;
  logic               overrun_inc;

  // Disabled pipelines count as finished so they never hold up completion.
  assign pipes_done  = &(pipelines_ready | ~pipelines_enabled);
  assign timeout_hit = (state == ST_PROCESS) && !pipes_done && (dwell == dwell_last);
  assign frame_inc   = (state == ST_TICK);
  assign overrun_inc = sample_ready && (state != ST_IDLE);
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      dwell         <= '0;
      gain_frame    <= '0;
      out_frame     <= '0;
      gain_valid    <= 1'b0;
      pipeline_tick <= 1'b0;
      mix_valid     <= 1'b0;
      out_valid     <= 1'b0;
      ready         <= 1'b1;
    end else begin
      gain_valid    <= 1'b0;
      pipeline_tick <= 1'b0;
      mix_valid     <= 1'b0;
      out_valid     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample_ready) begin
            gain_frame <= in_frame;
            ready      <= 1'b0;
            if (gain_bypass) begin
              state         <= ST_TICK;
              pipeline_tick <= 1'b1;
            end else begin
              state      <= ST_GAIN;
              gain_valid <= 1'b1;
            end
          end
        end
        ST_GAIN: begin
          if (gain_ready) begin
            state         <= ST_TICK;
            pipeline_tick <= 1'b1;
          end
        end
        ST_TICK: begin
          state <= ST_SETTLE;
        end
        // Pipelines may still show stale ready from the previous frame here.
        ST_SETTLE: begin
          state <= ST_PROCESS;
          dwell <= '0;
        end
        ST_PROCESS: begin
          if (pipes_done) begin
            state     <= ST_MIX;
            mix_valid <= 1'b1;
          end else if (timeout_hit) begin
            state     <= ST_IDLE;
            out_frame <= '0;
            out_valid <= 1'b1;
            ready     <= 1'b1;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        ST_MIX: begin
          if (mix_ready) begin
            state     <= ST_IDLE;
            out_frame <= mixed_frame;
            out_valid <= 1'b1;
            ready     <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.width(ctr_width)) u_frame_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (frame_inc),
    .sat_en (1'b0),
    .count  (frame_count)
  );

  sat_counter #(.width(ctr_width)) u_overrun_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (overrun_inc),
    .sat_en (1'b1),
    .count  (overrun_count)
  );

  sat_counter #(.width(ctr_width)) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .inc    (timeout_hit),
    .sat_en (1'b1),
    .count  (timeout_count)
  );

endmodule

// File: doc/engine_frame_sequencer.md
ENGINE_FRAME_SEQUENCER -- requirements
Module: engine_frame_sequencer

Interface
REQ-001 SHALL have parameter data_width, default 16, bits per lane sample.
REQ-002 SHALL have parameter n_lanes, default 2, audio lanes per frame (1..8).
REQ-003 SHALL have parameter n_pipelines, default 2, pipelines sequenced (1..8).
REQ-004 SHALL have parameter timeout_cycles, default 4096, maximum PROCESS dwell in clocks (>=2).
REQ-005 SHALL have parameter ctr_width, default 32, width of statistics counters.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 in_frame  in  n_lanes*data_width  input frame, lane 0 in LSBs.
REQ-009 sample_ready  in  1  one-cycle pulse, in_frame valid.
REQ-010 gain_bypass  in  1  skip input-gain handshake, sampled in IDLE.
REQ-011 gain_frame  out  n_lanes*data_width  latched in_frame to gain stage.
REQ-012 gain_valid  out  1  one-cycle request to gain stage.
REQ-013 gain_ready  in  1  gain stage result available.
REQ-014 pipeline_tick  out  1  one-cycle start pulse to all pipelines.
REQ-015 pipelines_ready  in  n_pipelines  per-pipeline idle/done.
REQ-016 pipelines_enabled  in  n_pipelines  1 = include pipeline in completion wait.
REQ-017 mix_valid  out  1  one-cycle request to mixer.
REQ-018 mix_ready  in  1  mixer result valid.
REQ-019 mixed_frame  in  n_lanes*data_width  mixer output.
REQ-020 out_frame  out  n_lanes*data_width  registered output frame.
REQ-021 out_valid  out  1  one-cycle pulse, out_frame updated.
REQ-022 ready  out  1  high only in IDLE.
REQ-023 frame_count, overrun_count, timeout_count  out  ctr_width each  statistics.
REQ-024 state_dbg  out  3  current state encoding.

Function
REQ-025 States SHALL be IDLE, GAIN, TICK, SETTLE, PROCESS, MIX.
REQ-026 IDLE: on sample_ready SHALL latch in_frame to gain_frame; if gain_bypass go TICK, else pulse gain_valid next cycle and go GAIN.
REQ-027 GAIN: on gain_ready SHALL go TICK; gain_valid SHALL not re-pulse.
REQ-028 TICK: SHALL pulse pipeline_tick exactly one cycle, increment frame_count (wrapping), go SETTLE.
REQ-029 SETTLE: one cycle, ready inputs ignored, then PROCESS.
REQ-030 PROCESS: when (pipelines_ready | ~pipelines_enabled) is all-ones SHALL pulse mix_valid and go MIX; with all pipelines disabled this occurs on first PROCESS cycle.
REQ-031 PROCESS dwell counter SHALL clear on entry; at timeout_cycles clocks without completion SHALL load out_frame with zero, pulse out_valid, increment timeout_count, go IDLE; no mix_valid.
REQ-032 MIX: on mix_ready SHALL register mixed_frame to out_frame, pulse out_valid same edge, go IDLE.
REQ-033 Bypass latency sample_ready-to-out_valid with instant ready/mix_ready SHALL be 5 clocks.
REQ-034 sample_ready in any state other than IDLE SHALL be dropped and increment overrun_count, including the cycle where MIX exits to IDLE.
REQ-035 overrun_count and timeout_count SHALL saturate at all-ones; frame_count SHALL wrap.
REQ-036 gain_ready, mix_ready outside their states SHALL be ignored.
REQ-037 out_frame SHALL hold its value between out_valid pulses.

Reset
REQ-038 reset low SHALL force IDLE, zero out_frame, gain_frame, all counters, all pulse outputs 0, ready 1 on following cycle.
REQ-039 reset mid-operation SHALL abandon the frame without out_valid or counter increment.

Structure
REQ-040 State encodings and default parameter values SHALL live in the shared engine package/header.
REQ-041 A sub-module sat_counter (width parameter, increment, saturate enable) SHALL implement all three counters.

Verification
REQ-042 Bypass, all ready, mix_ready 1 cycle after mix_valid, in_frame=0x1234_ABCD -> out_frame=mixed_frame, out_valid 5 clocks after sample_ready, frame_count=1.
REQ-043 Gain path, gain_ready 3 cycles after gain_valid -> pipeline_tick exactly once, latency 8 clocks.
REQ-044 Pipeline 1 disabled and never ready, pipeline 0 ready -> completes normally, timeout_count=0.
REQ-045 timeout_cycles=8, pipelines never ready -> out_frame=0, out_valid 8 clocks into PROCESS, timeout_count=1, no mix_valid.
REQ-046 sample_ready pulsed in GAIN, PROCESS and MIX-exit cycle -> overrun_count=3, one out_valid only.
REQ-047 reset low during PROCESS -> IDLE, ready=1, counters 0, no out_valid.
